// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions: widths, codeword bit positions,
// syndrome function and the nibble packer state encoding.
package ham_pkg;

    localparam int CW_W  = 7;
    localparam int NIB_W = 4;

    // Codeword bit positions, layout h6..h0 = D7 D6 D5 P4 D3 P2 P1
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D3 = 2;
    localparam int P4 = 3;
    localparam int D5 = 4;
    localparam int D6 = 5;
    localparam int D7 = 6;

    // Packer state encodings, kept as plain constants for older tools
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        HALF  = ST_HALF,
        FULL  = ST_FULL
    } pk_state_e;

    // Syndrome {s2, s1, s0}; zero for a consistent codeword
    function automatic logic [2:0] ham_syndrome(input logic [CW_W-1:0] cw);
        logic s0;
        logic s1;
        logic s2;
        s0 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s1 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s2 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return {s2, s1, s0};
    endfunction

endpackage

// File: rtl/hamming_nibble_packer_if.sv
// Codeword-in / byte-out stream bundle for the nibble packer.
// master = upstream/downstream environment, slave = packer.
interface hamming_nibble_packer_if #(
    parameter int CNT_W = 8
);
    import ham_pkg::*;

    logic [CW_W-1:0]  in_cw;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_cw, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, out_err, err_cnt
    );

    modport slave (
        input  in_cw, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, out_err, err_cnt
    );

endinterface

// File: rtl/ham_data_extract.sv
// Combinational codeword -> data nibble {D7,D6,D5,D3} plus a flag for a
// nonzero recomputed syndrome (only when HAM_SYNDROME_CHK_EN is defined).
module ham_data_extract
    import ham_pkg::*;
(
    input  logic [CW_W-1:0]  cw_i,
    output logic [NIB_W-1:0] nibble_o,
    output logic             syndrome_nz_o
);

    assign nibble_o = {cw_i[D7], cw_i[D6], cw_i[D5], cw_i[D3]};

`ifdef HAM_SYNDROME_CHK_EN
    assign syndrome_nz_o = |ham_syndrome(cw_i);
`else
    // Parity bits are not needed without the re-check
    logic unused_parity;
    assign unused_parity = ^{cw_i[P4], cw_i[P2], cw_i[P1]};
    assign syndrome_nz_o = 1'b0;
`endif

endmodule

// File: rtl/hamming_nibble_packer.sv
// Hamming(7,4) nibble packer: pairs data nibbles of consecutive corrected
// codewords into bytes on a valid/ready output.
// Optional macro HAM_SYNDROME_CHK_EN: re-check each codeword's syndrome,
// flag bytes with a failing nibble and count failures (saturating).
module hamming_nibble_packer
    import ham_pkg::*;
#(
    parameter bit               LSN_FIRST = 1'b1,
    parameter int               CNT_W     = 8,
    parameter logic [NIB_W-1:0] PAD_NIB   = 4'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    hamming_nibble_packer_if.slave  pk_if
);

    pk_state_e        state_q, state_d;
    logic [NIB_W-1:0] first_nib_q, first_nib_d;
    logic             first_err_q, first_err_d;
    logic [7:0]       out_data_q;
    logic             out_err_q;

    logic [NIB_W-1:0] nib;
    logic             nib_err;
    logic [NIB_W-1:0] second_nib;
    logic             second_err;
    logic             load_byte;
    logic [7:0]       packed_byte;
    logic             in_ready;
    logic             accept;
    logic             xfer;

    ham_data_extract u_extract (
        .cw_i          (pk_if.in_cw),
        .nibble_o      (nib),
        .syndrome_nz_o (nib_err)
    );

    // A stalled full byte only frees the input when downstream takes it
    assign in_ready = !rst && ((state_q != FULL) || pk_if.out_ready);
    assign accept   = pk_if.in_valid && in_ready;
    assign xfer     = (state_q == FULL) && pk_if.out_ready;

    generate
        if (LSN_FIRST) begin : gen_lsn_first
            assign packed_byte = {second_nib, first_nib_q};
        end else begin : gen_msn_first
            assign packed_byte = {first_nib_q, second_nib};
        end
    endgenerate

    // Next state; accept wins over flush in HALF, flush is ignored elsewhere
    always_comb begin
        state_d     = state_q;
        first_nib_d = first_nib_q;
        first_err_d = first_err_q;
        load_byte   = 1'b0;
        second_nib  = PAD_NIB;
        second_err  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = HALF;
                    first_nib_d = nib;
                    first_err_d = nib_err;
                end
            end
            HALF: begin
                if (accept) begin
                    state_d    = FULL;
                    load_byte  = 1'b1;
                    second_nib = nib;
                    second_err = nib_err;
                end else if (pk_if.flush) begin
                    state_d   = FULL;
                    load_byte = 1'b1;
                end
            end
            FULL: begin
                if (xfer) begin
                    if (accept) begin
                        state_d     = HALF;
                        first_nib_d = nib;
                        first_err_d = nib_err;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and byte registers; the byte only loads from HALF, so it is
    // never disturbed while a FULL byte waits on out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            first_nib_q <= '0;
            first_err_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_nib_q <= first_nib_d;
            first_err_q <= first_err_d;
            if (load_byte) begin
                out_data_q <= packed_byte;
                out_err_q  <= first_err_q | second_err;
            end
        end
    end

`ifdef HAM_SYNDROME_CHK_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && nib_err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Saturating count of codewords that fail the re-check
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pk_if.err_cnt = err_cnt_q;
`else
    assign pk_if.err_cnt = '0;
`endif

    assign pk_if.in_ready  = in_ready;
    assign pk_if.out_valid = (state_q == FULL);
    assign pk_if.out_data  = out_data_q;
    assign pk_if.out_err   = out_err_q;

endmodule

// File: tb/tb_hamming_nibble_packer.sv
// Directed bench for hamming_nibble_packer (LSN_FIRST=1, CNT_W=8, PAD_NIB=0).
// Nibble = {h6,h5,h4,h2}: 55->B, 33->6, 52->A, 00->0, 7F->F, 2D->5, 4B->8,
// 1E->3, 03->0 (03 has syndrome 3'b011, all others are valid codewords).
module tb_hamming_nibble_packer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    hamming_nibble_packer_if #(.CNT_W(8)) bus_if ();

    hamming_nibble_packer #(
        .LSN_FIRST (1'b1),
        .CNT_W     (8),
        .PAD_NIB   (4'h0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .pk_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        if (obs === exp) $display("check %s observed=%0h", tag, obs);
    endtask

    logic [6:0] stream_cw [8];
    logic [7:0] stream_byte [4];
    logic       exp_err;
    logic [7:0] exp_cnt;

    initial begin
        total = 0;
        bad   = 0;
        stream_cw   = '{7'h00, 7'h7F, 7'h55, 7'h33, 7'h52, 7'h2D, 7'h4B, 7'h1E};
        stream_byte = '{8'hF0, 8'h6B, 8'h5A, 8'h38};

        rst              = 1'b1;
        bus_if.in_cw     = 7'h00;
        bus_if.in_valid  = 1'b0;
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'h0);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus_if.out_data), 32'h00);
        chk("rst_out_err", 32'(bus_if.out_err), 32'h0);
        chk("rst_err_cnt", 32'(bus_if.err_cnt), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus_if.in_ready), 32'h1);

        // 1: basic pair, byte one cycle after second accept
        bus_if.in_valid = 1'b1;
        bus_if.in_cw    = 7'h55;
        tick();
        chk("t1_half_valid", 32'(bus_if.out_valid), 32'h0);
        bus_if.in_cw = 7'h33;
        tick();
        chk("t1_valid", 32'(bus_if.out_valid), 32'h1);
        chk("t1_data", 32'(bus_if.out_data), 32'h6B);
        chk("t1_err", 32'(bus_if.out_err), 32'h0);
        bus_if.in_valid = 1'b0;
        tick();
        chk("t1_drained", 32'(bus_if.out_valid), 32'h0);

        // 2: back-to-back stream, full throughput
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_if.in_cw = stream_cw[i];
            #1;
            chk($sformatf("t2_in_ready_%0d", i), 32'(bus_if.in_ready), 32'h1);
            tick();
            chk($sformatf("t2_valid_%0d", i), 32'(bus_if.out_valid), 32'(i % 2));
            if (i % 2 == 1)
                chk($sformatf("t2_data_%0d", i), 32'(bus_if.out_data), 32'(stream_byte[i/2]));
        end
        bus_if.in_valid = 1'b0;
        tick();
        chk("t2_drained", 32'(bus_if.out_valid), 32'h0);

        // 3: backpressure in FULL, then release with same-cycle accept
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.in_cw     = 7'h55;
        tick();
        bus_if.in_cw = 7'h33;
        tick();
        bus_if.in_cw = 7'h52;
        #1;
        chk("t3_stall_in_ready", 32'(bus_if.in_ready), 32'h0);
        tick();
        chk("t3_stall_valid", 32'(bus_if.out_valid), 32'h1);
        chk("t3_stall_data", 32'(bus_if.out_data), 32'h6B);
        tick();
        chk("t3_stall_data2", 32'(bus_if.out_data), 32'h6B);
        chk("t3_stall_in_ready2", 32'(bus_if.in_ready), 32'h0);
        bus_if.out_ready = 1'b1;
        #1;
        chk("t3_release_in_ready", 32'(bus_if.in_ready), 32'h1);
        tick();
        chk("t3_half_valid", 32'(bus_if.out_valid), 32'h0);
        bus_if.in_cw = 7'h2D;
        tick();
        chk("t3_next_valid", 32'(bus_if.out_valid), 32'h1);
        chk("t3_next_data", 32'(bus_if.out_data), 32'h5A);
        bus_if.in_valid = 1'b0;
        tick();

        // 4: flush closes a half byte; flush in FULL/EMPTY is a no-op
        bus_if.in_valid = 1'b1;
        bus_if.in_cw    = 7'h52;
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.flush    = 1'b1;
        tick();
        chk("t4_flush_valid", 32'(bus_if.out_valid), 32'h1);
        chk("t4_flush_data", 32'(bus_if.out_data), 32'h0A);
        tick();
        chk("t4_empty_after", 32'(bus_if.out_valid), 32'h0);
        tick();
        chk("t4_flush_empty", 32'(bus_if.out_valid), 32'h0);
        // accept beats flush in HALF
        bus_if.in_valid = 1'b1;
        bus_if.in_cw    = 7'h55;
        tick();
        bus_if.in_cw = 7'h33;
        tick();
        chk("t4_acc_beats_flush", 32'(bus_if.out_data), 32'h6B);
        bus_if.in_valid = 1'b0;
        bus_if.flush    = 1'b0;
        tick();

        // 5: syndrome re-check on a bad codeword
`ifdef HAM_SYNDROME_CHK_EN
        exp_err = 1'b1;
        exp_cnt = 8'h01;
`else
        exp_err = 1'b0;
        exp_cnt = 8'h00;
`endif
        bus_if.in_valid = 1'b1;
        bus_if.in_cw    = 7'h03;
        tick();
        chk("t5_cnt_first", 32'(bus_if.err_cnt), 32'(exp_cnt));
        bus_if.in_cw = 7'h55;
        tick();
        chk("t5_bad_data", 32'(bus_if.out_data), 32'hB0);
        chk("t5_bad_err", 32'(bus_if.out_err), 32'(exp_err));
        bus_if.in_cw = 7'h55;
        tick();
        bus_if.in_cw = 7'h33;
        tick();
        chk("t5_clean_err", 32'(bus_if.out_err), 32'h0);
        chk("t5_clean_cnt", 32'(bus_if.err_cnt), 32'(exp_cnt));
`ifdef HAM_SYNDROME_CHK_EN
        bus_if.in_cw = 7'h03;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (i == 252) chk("t5_cnt_fe", 32'(bus_if.err_cnt), 32'hFE);
        end
        chk("t5_cnt_sat", 32'(bus_if.err_cnt), 32'hFF);
`endif
        bus_if.in_valid = 1'b0;
        tick();

        // 6: reset while HALF discards the held nibble
        bus_if.in_valid = 1'b1;
        bus_if.in_cw    = 7'h55;
        tick();
        bus_if.in_valid = 1'b0;
        rst             = 1'b1;
        tick();
        chk("t6_rst_valid", 32'(bus_if.out_valid), 32'h0);
        chk("t6_rst_cnt", 32'(bus_if.err_cnt), 32'h0);
        chk("t6_rst_in_ready", 32'(bus_if.in_ready), 32'h0);
        rst             = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_cw    = 7'h33;
        tick();
        chk("t6_half_valid", 32'(bus_if.out_valid), 32'h0);
        bus_if.in_cw = 7'h52;
        tick();
        chk("t6_valid", 32'(bus_if.out_valid), 32'h1);
        chk("t6_data", 32'(bus_if.out_data), 32'hA6);
        bus_if.in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
